ram_bank_shifter: RTL
=====================

Name: ram_bank_shifter

Overview:
Parametrised successor to the single-bit RAM shifter. Serialises an IO_WIDTH-bit input word into an external single-port, async-read distributed RAM (RAM_WIDTH bits per word) one slot at a time. It reads slots back to rebuild a parallel output word. Adds a multi-bit RAM word, a two-bank double-buffer mode with frame-synchronous swap, a frame strobe and an async active-low reset; sits between board IO and a RAMxxX1S/RAMxxXnS-style primitive.

Parameters:
IO_WIDTH, 16, parallel in/out width.
RAM_WIDTH, 1, RAM data width; IO_WIDTH % RAM_WIDTH == 0. SLOTS = IO_WIDTH/RAM_WIDTH.
ADDR_WIDTH, 7, RAM address width; clog2(SLOTS) <= ADDR_WIDTH-1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
mode  in  1  0 = DIRECT, 1 = DOUBLE; sampled only at frame boundary.
swap  in  1  bank-swap request; any-cycle pulse, sticky until serviced.
in  in  IO_WIDTH  parallel input word.
out  out  IO_WIDTH  parallel output word, registered.
frame_done  out  1  one-cycle pulse at each frame boundary.
active_bank  out  1  bank currently read from, registered.
addr  out  ADDR_WIDTH  RAM address = {bank, zero pad, slot}; bank is bit ADDR_WIDTH-1.
ram_we  out  1  RAM write enable.
ram_in  out  RAM_WIDTH  RAM write data.
ram_out  in  RAM_WIDTH  RAM async read data.

Behaviour:
- Reset (rst_n low, async): out=0, frame_done=0, active_bank=0, slot=0, swap_pending=0, in_q=0, shadow=0, mode_q=0, state=IDLE. In IDLE: addr=0, ram_we=0, ram_in=0.
- addr/ram_we/ram_in are decoded only from flops (state, slot, active_bank, in_q); there is no combinational path from inputs.
- IDLE: exactly one cycle after reset release. On the leaving edge: in_q<=in, mode_q<=mode, go to DIRECT (mode=0) or WR (mode=1).
- DIRECT (1 cycle/slot): addr={active_bank, slot}, ram_we=1, ram_in=in_q[slot*RAM_WIDTH +: RAM_WIDTH]. On the edge, shadow slice[slot]<=ram_out; this is pre-write (old) content. Then slot++.
- WR: addr={~active_bank, slot}, ram_we=1, ram_in=in_q slice[slot]. Then go to RD.
- RD: addr={active_bank, slot}, ram_we=0, shadow slice[slot]<=ram_out. Then slot++ and go to WR.
- Frame length is SLOTS cycles in DIRECT and 2*SLOTS cycles in DOUBLE.
- Frame boundary is the edge that completes the last slot (DIRECT or RD with slot=SLOTS-1). On that edge:
  - out<=shadow, with the slice captured on that same edge merged in.
  - frame_done pulses 1 on the following cycle.
  - slot<=0.
  - in_q<=in.
  - mode_q<=mode; next state is DIRECT or WR accordingly.
  - If swap_pending or swap is high: active_bank toggles and swap_pending<=0.
- swap outside the boundary sets swap_pending. Multiple requests within one frame give a single toggle.
- Latency, DIRECT: in captured at boundary Bk appears on out at boundary Bk+2.
- Latency, DOUBLE: writes go to the inactive bank. out only changes once a swap exposes the bank. Without swap, out repeats the active bank contents each frame (hold).
- mode changes mid-frame are ignored until the boundary. A pending swap survives a mode change.
- Reset mid-frame aborts immediately. No partial out update.

Test Plan:
- Reset: rst_n low at cycle 7 of a DIRECT frame -> out, addr, ram_we, frame_done, active_bank all 0 in the same cycle. After release: 1 IDLE cycle, then addr 0,1,…,15 with ram_we=1.
- DIRECT, IO16/RAM1, RAM init 0, in=16'hA5C3 held -> frame_done every 16 cycles. out=0 at first boundary, out=16'hA5C3 at second.
- DOUBLE, RAM init 0, in=16'h1234, no swap -> frame_done every 32 cycles. Writes hit addr 64..79 with ram_in=bits of 0x1234; out stays 0 for 4 frames.
- Swap: as above plus swap pulsed twice mid-frame 2 -> active_bank becomes 1 at boundary 2 (single toggle). out=16'h1234 at boundary 3; next writes go to addr 0..15.
- RAM_WIDTH=4, IO_WIDTH=16, DIRECT, in=16'hBEEF -> 4-cycle frames. ram_in sequence F,E,E,B at addr 0..3; out=16'hBEEF at second boundary.
- mode toggled 0->1 at cycle 5 of a DIRECT frame -> frame still ends at cycle 16. WR/RD alternation starts after the boundary and frame_done period becomes 32.

Source files
------------

// File: rtl/ram_bank_shifter.sv
// ram_bank_shifter
// ----------------
// Moves an IO_WIDTH-bit parallel word through an external single-port RAM
// with async read. The RAM holds RAM_WIDTH bits per word. Each slot is one
// RAM_WIDTH slice of the word. The slots are read back to rebuild a parallel
// output word.
//
// DIRECT mode:
//   - One cycle per slot.
//   - The same address is read (the old contents) and then written, all in
//     one bank.
//
// DOUBLE mode:
//   - Two cycles per slot: a WR cycle, then an RD cycle.
//   - WR writes into the inactive bank. RD reads from the active bank.
//   - A swap request toggles the active bank at the next frame boundary.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   mode          0 = DIRECT, 1 = DOUBLE; sampled at frame boundaries only
//   swap          bank-swap request pulse; held pending until a boundary
//   in / out      parallel input word / registered parallel output word
//   frame_done    one-cycle pulse after each frame boundary
//   active_bank   bank that is currently read (registered)
//   addr          RAM address = {bank, zero pad, slot}
//   ram_we        RAM write enable
//   ram_in        RAM write data
//   ram_out       RAM async read data
module ram_bank_shifter #(
  parameter int IO_WIDTH   = 16,
  parameter int RAM_WIDTH  = 1,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  swap,
  input  logic [IO_WIDTH-1:0]   in,
  output logic [IO_WIDTH-1:0]   out,
  output logic                  frame_done,
  output logic                  active_bank,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  ram_we,
  output logic [RAM_WIDTH-1:0]  ram_in,
  input  logic [RAM_WIDTH-1:0]  ram_out
);

  localparam int SLOTS  = IO_WIDTH / RAM_WIDTH;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    WR     = 2'd2,
    RD     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                bank_q, bank_d;
  logic                swap_pend_q, swap_pend_d;
  logic                mode_q, mode_d;
  logic [IO_WIDTH-1:0] in_q, in_d;
  logic [IO_WIDTH-1:0] shadow_q, shadow_d;
  logic [IO_WIDTH-1:0] out_q, out_d;
  logic                fd_q, fd_d;

  // Combinational helper signals.
  logic [RAM_WIDTH-1:0] cur_slice;
  logic [IO_WIDTH-1:0]  shadow_cap;
  logic                 addr_bank;
  logic                 capture;
  logic                 boundary;

  // Select the current slot with a constant-index mux.
  // Using slot_q directly as a part-select base would risk width mismatches.
  always_comb begin
    cur_slice  = '0;
    shadow_cap = shadow_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_q == SLOT_W'(s)) begin
        cur_slice                           = in_q[s*RAM_WIDTH +: RAM_WIDTH];
        shadow_cap[s*RAM_WIDTH +: RAM_WIDTH] = ram_out;
      end
    end
  end

  // Next-state logic and RAM-side decode.
  // The RAM-side outputs depend only on registered state, never on the
  // module inputs.
  always_comb begin
    // NOTE: every signal gets a default first.
    // Without it, any path that skips an assignment would infer a latch.
    state_d     = state_q;
    slot_d      = slot_q;
    bank_d      = bank_q;
    swap_pend_d = swap_pend_q | swap;
    mode_d      = mode_q;
    in_d        = in_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    fd_d        = 1'b0;
    addr_bank   = 1'b0;
    ram_we      = 1'b0;
    ram_in      = '0;
    capture     = 1'b0;
    boundary    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_d    = in;
        mode_d  = mode;
        state_d = mode ? WR : DIRECT;
      end
      DIRECT: begin
        addr_bank = bank_q;
        ram_we    = 1'b1;
        ram_in    = cur_slice;
        capture   = 1'b1;
        slot_d    = slot_q + 1'b1;
        boundary  = (slot_q == LAST_SLOT);
      end
      WR: begin
        // Writes land in the bank that is not being read.
        addr_bank = ~bank_q;
        ram_we    = 1'b1;
        ram_in    = cur_slice;
        state_d   = RD;
      end
      RD: begin
        addr_bank = bank_q;
        capture   = 1'b1;
        slot_d    = slot_q + 1'b1;
        state_d   = WR;
        boundary  = (slot_q == LAST_SLOT);
      end
      default: state_d = IDLE;
    endcase

    // RAM reads are async, so this captures the old contents in DIRECT mode.
    if (capture) shadow_d = shadow_cap;

    if (boundary) begin
      // Include the slice captured on this same edge in the output word.
      out_d   = shadow_cap;
      fd_d    = 1'b1;
      slot_d  = '0;
      in_d    = in;
      mode_d  = mode;
      state_d = mode ? WR : DIRECT;
      // Several requests in one frame collapse into a single toggle.
      if (swap_pend_q || swap) bank_d = ~bank_q;
      swap_pend_d = 1'b0;
    end

    addr                = '0;
    addr[ADDR_WIDTH-1]  = addr_bank;
    addr[SLOT_W-1:0]    = slot_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      mode_q      <= 1'b0;
      in_q        <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      fd_q        <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments here.
      // Every flop must see the pre-edge values of the others.
      state_q     <= state_d;
      slot_q      <= slot_d;
      bank_q      <= bank_d;
      swap_pend_q <= swap_pend_d;
      mode_q      <= mode_d;
      in_q        <= in_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      fd_q        <= fd_d;
    end
  end

  assign out         = out_q;
  assign frame_done  = fd_q;
  assign active_bank = bank_q;

endmodule
